axis_packet_arbiter: RTL and testbench

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/axis_arb_pkg.sv | 14 +
 rtl/axis_packet_arbiter_rr_picker.sv | 31 +++
 rtl/axis_packet_arbiter.sv | 125 ++++++++++++
 tb/tb_axis_packet_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a source index: at least one bit, even for tiny arbiters.
  function automatic int calcIdW(input int nS);
    return (nS > 2) ? $clog2(nS) : 1;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, wrapping around.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  int            cand;
  logic [W-1:0]  candIdx;

  // Walk the requests starting at the pointer and keep the first hit.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int k = 0; k < N; k++) begin
      cand    = (int'(ptr_i) + k) % N;
      candIdx = W'(cand);
      if (!valid_o && req_i[candIdx]) begin
        valid_o = 1'b1;
        idx_o   = candIdx;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Merges N_S AXI-Stream sources into one stream, whole packets at a time,
// with round-robin fairness and a single registered output stage.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int N_S            = 4,
  parameter  int WORD_W         = 8,
  parameter  int BUS_W          = 8,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W,
  localparam int ID_W           = calcIdW(N_S)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_S-1:0]                               s_valid,
  output logic [N_S-1:0]                               s_ready,
  input  logic [N_S-1:0]                               s_last,
  input  logic [N_S-1:0][WORDS_PER_BEAT-1:0]           s_keep,
  input  logic [N_S-1:0][WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
  output logic                                         m_valid,
  output logic                                         m_last,
  input  logic                                         m_ready,
  output logic [WORDS_PER_BEAT-1:0]                    m_keep,
  output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]        m_data,
  output logic [ID_W-1:0]                              m_id
);

  localparam logic [ID_W-1:0] LastIdx = ID_W'(N_S - 1);

  arb_state_e                            state_q, state_d;
  logic [ID_W-1:0]                       grant_q, grant_d;
  logic [ID_W-1:0]                       lastGrant_q, lastGrant_d;
  logic [ID_W-1:0]                       pickPtr, pickIdx;
  logic                                  pickValid;
  logic                                  grantReady;
  logic                                  beatXfer;

  logic                                  mValid_q;
  logic                                  mLast_q;
  logic [WORDS_PER_BEAT-1:0]             mKeep_q;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] mData_q;
  logic [ID_W-1:0]                       mId_q;

  // Search starts one past the last source that completed a packet.
  always_comb begin
    if (lastGrant_q == LastIdx) pickPtr = '0;
    else                        pickPtr = lastGrant_q + 1'b1;
  end

  rr_picker #(
    .N (N_S),
    .W (ID_W)
  ) uPicker (
    .req_i   (s_valid),
    .ptr_i   (pickPtr),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  // Arbitration FSM: pick in IDLE, stream the granted packet in BUSY.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    lastGrant_d = lastGrant_q;
    s_ready     = '0;
    grantReady  = 1'b0;
    beatXfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          grant_d = pickIdx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        grantReady       = !mValid_q || m_ready;
        s_ready[grant_q] = grantReady;
        beatXfer         = s_valid[grant_q] && grantReady;
        if (beatXfer && s_last[grant_q]) begin
          lastGrant_d = grant_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers; reset points the search at source 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= LastIdx;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Single-entry output register: load on transfer, drop valid once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mValid_q <= 1'b0;
      mLast_q  <= 1'b0;
      mKeep_q  <= '0;
      mData_q  <= '0;
      mId_q    <= '0;
    end else if (beatXfer) begin
      mValid_q <= 1'b1;
      mLast_q  <= s_last[grant_q];
      mKeep_q  <= s_keep[grant_q];
      mData_q  <= s_data[grant_q];
      mId_q    <= grant_q;
    end else if (m_ready) begin
      mValid_q <= 1'b0;
    end
  end

  assign m_valid = mValid_q;
  assign m_last  = mLast_q;
  assign m_keep  = mKeep_q;
  assign m_data  = mData_q;
  assign m_id    = mId_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: directed scenarios plus a
// randomized run scored against per-source sent/received sequences.
module tb_axis_packet_arbiter;

  localparam int N      = 4;
  localparam int WW     = 8;
  localparam int BW     = 8;
  localparam int WPB    = BW / WW;
  localparam int IDW    = 2;
  localparam int DW     = WPB * WW;
  localparam int BEAT_W = WPB + 1 + DW;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef struct {
    int    id;
    beat_t beat;
    int    cyc;
  } rx_t;

  logic                         clk;
  logic                         rst;
  logic [N-1:0]                 s_valid;
  logic [N-1:0]                 s_ready;
  logic [N-1:0]                 s_last;
  logic [N-1:0][WPB-1:0]        s_keep;
  logic [N-1:0][WPB-1:0][WW-1:0] s_data;
  logic                         m_valid;
  logic                         m_last;
  logic                         m_ready;
  logic [WPB-1:0]               m_keep;
  logic [WPB-1:0][WW-1:0]       m_data;
  logic [IDW-1:0]               m_id;

  beat_t txQ [N][$];
  rx_t   rxQ [$];
  int    validPct;
  int    readyPct;
  int    cycleNo;
  int    checkCount;
  int    passCount;

  axis_packet_arbiter #(
    .N_S    (N),
    .WORD_W (WW),
    .BUS_W  (BW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_keep  (s_keep),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .m_keep  (m_keep),
    .m_data  (m_data),
    .m_id    (m_id)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Last-resort guard so a wedged run still terminates.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic beat_t mkBeat(input int data, input bit last);
    return {{WPB{1'b1}}, last, DW'(data)};
  endfunction

  // Present the head of each source queue (or idle junk) and pick m_ready.
  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      if (txQ[i].size() > 0 && int'($urandom_range(99, 0)) < validPct) begin
        s_valid[i] = 1'b1;
        {s_keep[i], s_last[i], s_data[i]} = txQ[i][0];
      end else begin
        s_valid[i] = 1'b0;
        s_keep[i]  = WPB'($urandom);
        s_last[i]  = 1'($urandom);
        s_data[i]  = DW'($urandom);
      end
    end
    m_ready = (int'($urandom_range(99, 0)) < readyPct);
  endtask

  // One clock: note handshakes at the falling edge, retire them after the rise.
  task automatic cycle();
    bit  acc [N];
    rx_t r;
    @(negedge clk);
    for (int i = 0; i < N; i++) acc[i] = s_valid[i] && s_ready[i];
    if (m_valid && m_ready) begin
      r.id   = int'(m_id);
      r.beat = {m_keep, m_last, m_data};
      r.cyc  = cycleNo;
      rxQ.push_back(r);
    end
    cycleNo++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(txQ[i].pop_front());
    driveInputs();
    #1;
  endtask

  task automatic doReset();
    rst     = 1'b1;
    s_valid = '0;
    s_last  = '0;
    s_keep  = '0;
    s_data  = '0;
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) txQ[i].delete();
    rxQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    s_valid = '1;
    s_last  = '1;
    s_keep  = '1;
    s_data  = '1;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkCount++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %b want 0", m_valid); else passCount++;
    checkCount++; if (m_last !== 1'b0) $display("[TB] FAIL reset_m_last: got %b want 0", m_last); else passCount++;
    checkCount++; if (m_keep !== '0) $display("[TB] FAIL reset_m_keep: got %h want 0", m_keep); else passCount++;
    checkCount++; if (m_data !== '0) $display("[TB] FAIL reset_m_data: got %h want 0", m_data); else passCount++;
    checkCount++; if (m_id !== '0) $display("[TB] FAIL reset_m_id: got %0d want 0", m_id); else passCount++;
    checkCount++; if (s_ready !== '0) $display("[TB] FAIL reset_s_ready: got %b want 0000", s_ready); else passCount++;
    doReset();
  endtask

  task automatic test_two_sources();
    int expData [6] = '{'h10, 'h11, 'h12, 'h20, 'h21, 'h22};
    int expId   [6] = '{0, 0, 0, 2, 2, 2};
    bit expLast [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int expGap  [5] = '{1, 1, 2, 1, 1};
    doReset();
    validPct = 100;
    readyPct = 100;
    for (int k = 0; k < 3; k++) begin
      txQ[0].push_back(mkBeat('h10 + k, k == 2));
      txQ[2].push_back(mkBeat('h20 + k, k == 2));
    end
    for (int t = 0; t < 60 && rxQ.size() < 6; t++) cycle();
    checkCount++; if (rxQ.size() != 6) $display("[TB] FAIL two_src_count: got %0d beats want 6", rxQ.size()); else passCount++;
    for (int k = 0; k < 6 && k < rxQ.size(); k++) begin
      checkCount++; if (rxQ[k].beat[DW-1:0] !== DW'(expData[k])) $display("[TB] FAIL two_src_data[%0d]: got %h want %h", k, rxQ[k].beat[DW-1:0], expData[k]); else passCount++;
      checkCount++; if (rxQ[k].id != expId[k]) $display("[TB] FAIL two_src_id[%0d]: got %0d want %0d", k, rxQ[k].id, expId[k]); else passCount++;
      checkCount++; if (rxQ[k].beat[DW] !== expLast[k]) $display("[TB] FAIL two_src_last[%0d]: got %b want %b", k, rxQ[k].beat[DW], expLast[k]); else passCount++;
      if (k > 0) begin
        checkCount++; if (rxQ[k].cyc - rxQ[k-1].cyc != expGap[k-1]) $display("[TB] FAIL two_src_gap[%0d]: got %0d cycles want %0d", k, rxQ[k].cyc - rxQ[k-1].cyc, expGap[k-1]); else passCount++;
      end
    end
  endtask

  task automatic test_round_robin();
    int cnt [N] = '{3, 2, 2, 1};
    int rem [N];
    int expId [$];
    int expData [$];
    int lastWin;
    int total;
    doReset();
    validPct = 100;
    readyPct = 100;
    total = 0;
    for (int s = 0; s < N; s++) begin
      for (int k = 0; k < cnt[s]; k++) txQ[s].push_back(mkBeat((s << 4) | k, 1'b1));
      rem[s] = cnt[s];
      total += cnt[s];
    end
    lastWin = N - 1;
    while (expId.size() < total) begin
      for (int step = 1; step <= N; step++) begin
        int c;
        c = (lastWin + step) % N;
        if (rem[c] > 0) begin
          expId.push_back(c);
          expData.push_back((c << 4) | (cnt[c] - rem[c]));
          rem[c]--;
          lastWin = c;
          break;
        end
      end
    end
    for (int t = 0; t < 80 && rxQ.size() < total; t++) cycle();
    checkCount++; if (rxQ.size() != total) $display("[TB] FAIL rr_count: got %0d packets want %0d", rxQ.size(), total); else passCount++;
    for (int k = 0; k < total && k < rxQ.size(); k++) begin
      checkCount++; if (rxQ[k].id != expId[k]) $display("[TB] FAIL rr_id[%0d]: got %0d want %0d", k, rxQ[k].id, expId[k]); else passCount++;
      checkCount++; if (rxQ[k].beat[DW-1:0] !== DW'(expData[k])) $display("[TB] FAIL rr_data[%0d]: got %h want %h", k, rxQ[k].beat[DW-1:0], expData[k]); else passCount++;
      checkCount++; if (rxQ[k].beat[DW] !== 1'b1) $display("[TB] FAIL rr_last[%0d]: got %b want 1", k, rxQ[k].beat[DW]); else passCount++;
    end
  endtask

  task automatic test_single_requester();
    doReset();
    validPct = 100;
    readyPct = 100;
    for (int j = 0; j < 6; j++) txQ[3].push_back(mkBeat('h60 + j, (j % 2) == 1));
    for (int t = 0; t < 60 && rxQ.size() < 6; t++) cycle();
    checkCount++; if (rxQ.size() != 6) $display("[TB] FAIL single_count: got %0d beats want 6", rxQ.size()); else passCount++;
    for (int k = 0; k < 6 && k < rxQ.size(); k++) begin
      checkCount++; if (rxQ[k].id != 3) $display("[TB] FAIL single_id[%0d]: got %0d want 3", k, rxQ[k].id); else passCount++;
      checkCount++; if (rxQ[k].beat[DW-1:0] !== DW'('h60 + k)) $display("[TB] FAIL single_data[%0d]: got %h want %h", k, rxQ[k].beat[DW-1:0], 'h60 + k); else passCount++;
      if (k > 0) begin
        checkCount++; if (rxQ[k].cyc - rxQ[k-1].cyc != ((k % 2 == 0) ? 2 : 1)) $display("[TB] FAIL single_gap[%0d]: got %0d cycles want %0d", k, rxQ[k].cyc - rxQ[k-1].cyc, (k % 2 == 0) ? 2 : 1); else passCount++;
      end
    end
  endtask

  task automatic test_backpressure();
    int held;
    doReset();
    validPct = 100;
    readyPct = 100;
    for (int j = 0; j < 6; j++) txQ[1].push_back(mkBeat('h30 + j, j == 5));
    for (int t = 0; t < 20 && rxQ.size() < 1; t++) cycle();
    checkCount++; if (rxQ.size() < 1) $display("[TB] FAIL bp_start: got %0d beats want at least 1", rxQ.size()); else passCount++;
    readyPct = 0;
    cycle();
    held = 'h30 + rxQ.size();
    for (int t = 0; t < 10; t++) begin
      checkCount++; if (m_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid[%0d]: got %b want 1", t, m_valid); else passCount++;
      checkCount++; if (m_data !== DW'(held)) $display("[TB] FAIL bp_hold_data[%0d]: got %h want %h", t, m_data, held); else passCount++;
      checkCount++; if (s_ready !== '0) $display("[TB] FAIL bp_hold_ready[%0d]: got %b want 0000", t, s_ready); else passCount++;
      cycle();
    end
    readyPct = 100;
    for (int t = 0; t < 40 && rxQ.size() < 6; t++) cycle();
    checkCount++; if (rxQ.size() != 6) $display("[TB] FAIL bp_count: got %0d beats want 6", rxQ.size()); else passCount++;
    for (int k = 0; k < 6 && k < rxQ.size(); k++) begin
      checkCount++; if (rxQ[k].beat[DW-1:0] !== DW'('h30 + k)) $display("[TB] FAIL bp_data[%0d]: got %h want %h", k, rxQ[k].beat[DW-1:0], 'h30 + k); else passCount++;
      checkCount++; if (rxQ[k].beat[DW] !== (k == 5)) $display("[TB] FAIL bp_last[%0d]: got %b want %b", k, rxQ[k].beat[DW], k == 5); else passCount++;
    end
  endtask

  task automatic test_reset_mid_packet();
    doReset();
    validPct = 100;
    readyPct = 100;
    txQ[0].push_back(mkBeat('h0A, 1'b1));
    for (int j = 0; j < 5; j++) txQ[1].push_back(mkBeat('h40 + j, j == 4));
    for (int t = 0; t < 30 && rxQ.size() < 3; t++) cycle();
    checkCount++; if (rxQ.size() < 3) $display("[TB] FAIL rstmid_start: got %0d beats want 3", rxQ.size()); else passCount++;
    for (int k = 1; k < 3 && k < rxQ.size(); k++) begin
      checkCount++; if (rxQ[k].id != 1 || rxQ[k].beat[DW] !== 1'b0) $display("[TB] FAIL rstmid_pre[%0d]: got id %0d last %b want id 1 last 0", k, rxQ[k].id, rxQ[k].beat[DW]); else passCount++;
    end
    rst     = 1'b1;
    s_valid = '1;
    txQ[1].delete();
    txQ[0].push_back(mkBeat('h50, 1'b1));
    txQ[3].push_back(mkBeat('h5F, 1'b1));
    rxQ.delete();
    #1;
    checkCount++; if (m_valid !== 1'b0) $display("[TB] FAIL rstmid_m_valid: got %b want 0", m_valid); else passCount++;
    checkCount++; if (m_last !== 1'b0) $display("[TB] FAIL rstmid_m_last: got %b want 0", m_last); else passCount++;
    checkCount++; if (s_ready !== '0) $display("[TB] FAIL rstmid_s_ready: got %b want 0000", s_ready); else passCount++;
    s_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 20 && rxQ.size() < 2; t++) cycle();
    checkCount++; if (rxQ.size() != 2) $display("[TB] FAIL rstmid_count: got %0d beats want 2", rxQ.size()); else passCount++;
    if (rxQ.size() >= 2) begin
      checkCount++; if (rxQ[0].id != 0 || rxQ[0].beat[DW-1:0] !== DW'('h50)) $display("[TB] FAIL rstmid_first: got id %0d data %h want id 0 data 50", rxQ[0].id, rxQ[0].beat[DW-1:0]); else passCount++;
      checkCount++; if (rxQ[1].id != 3 || rxQ[1].beat[DW-1:0] !== DW'('h5F)) $display("[TB] FAIL rstmid_second: got id %0d data %h want id 3 data 5f", rxQ[1].id, rxQ[1].beat[DW-1:0]); else passCount++;
    end
  endtask

  task automatic test_random();
    beat_t expQ [N][$];
    int    rxIdx [N];
    int    errs [N];
    int    total;
    int    owner;
    int    interleaves;
    doReset();
    validPct = int'($urandom_range(90, 80));
    readyPct = int'($urandom_range(90, 80));
    total = 0;
    for (int s = 0; s < N; s++) begin
      rxIdx[s] = 0;
      errs[s]  = 0;
      for (int p = 0; p < 100; p++) begin
        int len;
        len = int'($urandom_range(100, 1));
        for (int w = 0; w < len; w++) begin
          beat_t b;
          b = {WPB'($urandom), (w == len - 1), DW'($urandom)};
          txQ[s].push_back(b);
          expQ[s].push_back(b);
          total++;
        end
      end
    end
    for (int t = 0; t < 80000 && rxQ.size() < total; t++) cycle();
    checkCount++; if (rxQ.size() != total) $display("[TB] FAIL rand_timeout: got %0d beats want %0d", rxQ.size(), total); else passCount++;
    owner = -1;
    interleaves = 0;
    foreach (rxQ[k]) begin
      int id;
      id = rxQ[k].id;
      if (owner >= 0 && id != owner) interleaves++;
      owner = rxQ[k].beat[DW] ? -1 : id;
      if (rxIdx[id] >= expQ[id].size() || rxQ[k].beat !== expQ[id][rxIdx[id]]) begin
        if (errs[id] == 0) $display("[TB] rand source %0d first divergence at word %0d", id, rxIdx[id]);
        errs[id]++;
      end
      rxIdx[id]++;
    end
    checkCount++; if (interleaves != 0) $display("[TB] FAIL rand_interleave: got %0d switches want 0", interleaves); else passCount++;
    for (int s = 0; s < N; s++) begin
      checkCount++; if (rxIdx[s] != expQ[s].size()) $display("[TB] FAIL rand_count[%0d]: got %0d words want %0d", s, rxIdx[s], expQ[s].size()); else passCount++;
      checkCount++; if (errs[s] != 0) $display("[TB] FAIL rand_seq[%0d]: got %0d bad words want 0", s, errs[s]); else passCount++;
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checkCount = 0;
    passCount  = 0;
    cycleNo    = 0;
    validPct   = 100;
    readyPct   = 100;
    rst        = 1'b1;
    s_valid    = '0;
    s_last     = '0;
    s_keep     = '0;
    s_data     = '0;
    m_ready    = 1'b0;
    test_reset();
    test_two_sources();
    test_round_robin();
    test_single_requester();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
